// File: rtl/params_noc.sv
// Shared NoC types: flit format, port ids, flit labels and the per-VC input state.
package params_noc;
  localparam int VC_Size = 2;
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, EAST, WEST} inout_Port;
  typedef enum logic [1:0] {IDLE, VC_ALLOC, ACTIVE} vc_state_t;

  typedef struct packed {
    flit_label_t         flit_label;
    logic [VC_Size-1:0]  vc;
    logic [DATA_W-1:0]   data;
  } flit_Data_withvc;

  function automatic logic is_head(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction
endpackage

// File: rtl/vc_input_unit_fifo.sv
// Per-VC flit FIFO; pointers carry an extra wrap bit so full and empty differ.
module vc_fifo #(
  parameter int BUFFER_SIZE = 8,
  parameter int W           = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(BUFFER_SIZE);

  logic [W-1:0] mem [BUFFER_SIZE];
  logic [AW:0]  wp, rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
    end
  end

  // Storage is not reset: clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/vc_input_unit.sv
// Multi-VC router input unit: per-VC FIFO + packet FSM, credit return, output mux.
// Optional VC_INPUT_ERR_COUNT_EN adds per-VC saturating error counters (err_Count).
module vc_input_unit
  import params_noc::*;
#(
  parameter int NUM_VC      = 4,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_i,
  input  flit_Data_withvc           input_Data,
  input  inout_Port                 port_i,
  output logic [NUM_VC-1:0]         vc_Req,
  input  logic [NUM_VC-1:0]         vc_Val,
  input  logic [NUM_VC*VC_Size-1:0] vc_New,
  output logic [NUM_VC-1:0]         switch_Req,
  input  logic [NUM_VC-1:0]         read_i,
  output flit_Data_withvc           output_Data,
  output inout_Port                 port_o,
  output logic                      credit_o,
  output logic [VC_Size-1:0]        credit_vc_o,
  output logic [NUM_VC-1:0]         vc_Free,
  output logic [NUM_VC-1:0]         buf_empty,
  output logic [NUM_VC-1:0]         buf_full,
  output logic [NUM_VC-1:0]         err
`ifdef VC_INPUT_ERR_COUNT_EN
  , output logic [NUM_VC-1:0][7:0]  err_Count
`endif
);
  localparam int FW = $bits(flit_Data_withvc);

  logic               rd_onehot;
  logic [NUM_VC-1:0]  pop_v;
  flit_Data_withvc    head_arr [NUM_VC];
  logic [VC_Size-1:0] dvc_arr  [NUM_VC];
  inout_Port          port_arr [NUM_VC];
  logic [VC_Size-1:0] credit_d;

  assign rd_onehot = $onehot(read_i);

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_state_t          state_q, state_d;
    logic               end_q, free_q, err_q;
    logic [VC_Size-1:0] dvc_q;
    inout_Port          port_q;
    logic [FW-1:0]      head_raw;
    flit_Data_withvc    head;
    logic               empty, full;
    logic               wr_hit, wr_err, wr_ok, rd_ok, rd_err, val_err, tail_pop;

    vc_fifo #(.BUFFER_SIZE(BUFFER_SIZE), .W(FW)) u_fifo (
      .clk(clk), .rst(rst), .push(wr_ok), .pop(rd_ok),
      .din(input_Data), .dout(head_raw), .empty(empty), .full(full)
    );

    assign head     = flit_Data_withvc'(head_raw);
    assign wr_hit   = write_i && (input_Data.vc == VC_Size'(v));
    assign rd_ok    = read_i[v] && rd_onehot && (state_q == ACTIVE) && !empty;
    assign rd_err   = read_i[v] && !rd_ok;
    assign val_err  = vc_Val[v] && (state_q != VC_ALLOC);
    assign tail_pop = rd_ok && is_tail(head.flit_label);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign wr_err   = wr_hit && ((is_head(input_Data.flit_label) ? (state_q != IDLE)
                                                                  : (state_q == IDLE))
                                 || end_q || (full && !rd_ok));
    assign wr_ok    = wr_hit && !wr_err;

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:     if (wr_ok && is_head(input_Data.flit_label)) state_d = VC_ALLOC;
        VC_ALLOC: if (vc_Val[v]) state_d = ACTIVE;
        ACTIVE:   if (tail_pop) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        end_q   <= 1'b0;
        dvc_q   <= '0;
        port_q  <= LOCAL;
        free_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        if (wr_ok && is_head(input_Data.flit_label)) port_q <= port_i;
        if (wr_ok && is_tail(input_Data.flit_label)) end_q <= 1'b1;
        else if (tail_pop)                           end_q <= 1'b0;
        if ((state_q == VC_ALLOC) && vc_Val[v]) dvc_q <= vc_New[v*VC_Size +: VC_Size];
        free_q  <= tail_pop;
        err_q   <= wr_err || rd_err || val_err;
      end
    end

`ifdef VC_INPUT_ERR_COUNT_EN
    logic [7:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                             cnt_q <= '0;
      else if ((wr_err || rd_err || val_err) && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
    assign err_Count[v] = cnt_q;
`endif

    assign vc_Req[v]     = (state_q == VC_ALLOC);
    assign switch_Req[v] = (state_q == ACTIVE) && !empty;
    assign buf_empty[v]  = empty;
    assign buf_full[v]   = full;
    assign vc_Free[v]    = free_q;
    assign err[v]        = err_q;
    assign pop_v[v]      = rd_ok;
    assign head_arr[v]   = head;
    assign dvc_arr[v]    = dvc_q;
    assign port_arr[v]   = port_q;
  end

  always_comb begin
    output_Data = '0;
    port_o      = LOCAL;
    if (rd_onehot) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (read_i[v]) begin
          output_Data    = head_arr[v];
          output_Data.vc = dvc_arr[v];
          port_o         = port_arr[v];
        end
      end
    end
  end

  always_comb begin
    credit_d = '0;
    for (int v = 0; v < NUM_VC; v++) if (pop_v[v]) credit_d = VC_Size'(v);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_o    <= 1'b0;
      credit_vc_o <= '0;
    end else begin
      credit_o    <= |pop_v;
      credit_vc_o <= credit_d;
    end
  end
endmodule

// File: tb/tb_vc_input_unit.sv
// Directed + random bench for vc_input_unit against a queue-based packet model.
module tb_vc_input_unit;
  import params_noc::*;
  localparam int NV = 4;
  localparam int BS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  write_i;
  flit_Data_withvc       input_Data;
  inout_Port             port_i;
  logic [NV-1:0]         vc_Req, vc_Val, switch_Req, read_i, vc_Free, buf_empty, buf_full, err;
  logic [NV*VC_Size-1:0] vc_New;
  flit_Data_withvc       output_Data;
  inout_Port             port_o;
  logic                  credit_o;
  logic [VC_Size-1:0]    credit_vc_o;
`ifdef VC_INPUT_ERR_COUNT_EN
  logic [NV-1:0][7:0]    err_Count;
`endif

  vc_input_unit #(.NUM_VC(NV), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .rst(rst), .write_i(write_i), .input_Data(input_Data), .port_i(port_i),
    .vc_Req(vc_Req), .vc_Val(vc_Val), .vc_New(vc_New), .switch_Req(switch_Req),
    .read_i(read_i), .output_Data(output_Data), .port_o(port_o), .credit_o(credit_o),
    .credit_vc_o(credit_vc_o), .vc_Free(vc_Free), .buf_empty(buf_empty),
    .buf_full(buf_full), .err(err)
`ifdef VC_INPUT_ERR_COUNT_EN
    , .err_Count(err_Count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one flit queue and packet phase per VC (0 idle, 1 awaiting VC, 2 active).
  flit_Data_withvc    q [NV][$];
  int                 ph   [NV];
  bit                 endp [NV];
  logic [VC_Size-1:0] dvc  [NV];
  inout_Port          prt  [NV];
  int                 cnt  [NV];
  logic               x_credit;
  logic [VC_Size-1:0] x_cvc;
  logic [NV-1:0]      x_free, x_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      q[v].delete(); ph[v] = 0; endp[v] = 0; dvc[v] = '0; prt[v] = LOCAL; cnt[v] = 0;
    end
    x_credit = 0; x_cvc = '0; x_free = '0; x_err = '0;
  endtask

  task automatic inputs_idle();
    write_i = 0; input_Data = '0; port_i = LOCAL; vc_Val = '0; vc_New = '0; read_i = '0;
  endtask

  task automatic put(input int v, input flit_label_t l, input logic [15:0] d, input inout_Port p);
    logic [31:0] vv;
    vv = v;
    write_i = 1; input_Data.flit_label = l; input_Data.vc = vv[VC_Size-1:0];
    input_Data.data = d; port_i = p;
  endtask

  task automatic grant(input int v, input int nv);
    logic [31:0] t;
    t = nv;
    vc_Val[v] = 1'b1;
    vc_New[v*VC_Size +: VC_Size] = t[VC_Size-1:0];
  endtask

  // Check outputs at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    logic [NV-1:0]   ereq, esw, eemp, efull, nerr, nfree, valgo;
    flit_Data_withvc eo, f;
    int pv, w;
    bit pop, oh, ok;
    @(negedge clk);
    for (int v = 0; v < NV; v++) begin
      ereq[v]  = (ph[v] == 1);
      esw[v]   = (ph[v] == 2) && (q[v].size() != 0);
      eemp[v]  = (q[v].size() == 0);
      efull[v] = (q[v].size() == BS);
    end
    chk("vc_Req", vc_Req, ereq);
    chk("switch_Req", switch_Req, esw);
    chk("buf_empty", buf_empty, eemp);
    chk("buf_full", buf_full, efull);
    chk("err", err, x_err);
    chk("vc_Free", vc_Free, x_free);
    chk("credit_o", credit_o, x_credit);
    if (x_credit) chk("credit_vc_o", credit_vc_o, x_cvc);
`ifdef VC_INPUT_ERR_COUNT_EN
    for (int v = 0; v < NV; v++) chk("err_Count", err_Count[v], cnt[v]);
`endif
    oh = ($countones(read_i) == 1);
    pv = -1;
    for (int v = 0; v < NV; v++) if (oh && read_i[v]) pv = v;
    if (read_i == '0) chk("output_Data_idle", output_Data, 0);
    else if (pv >= 0 && q[pv].size() != 0) begin
      eo = q[pv][0]; eo.vc = dvc[pv];
      chk("output_Data", output_Data, eo);
      chk("port_o", port_o, prt[pv]);
    end
    nerr = '0; nfree = '0; pop = 0; ok = 0; w = 0;
    for (int v = 0; v < NV; v++) begin
      if (read_i[v]) begin
        if (oh && ph[v] == 2 && q[v].size() != 0) pop = 1;
        else nerr[v] = 1'b1;
      end
      valgo[v] = vc_Val[v] && (ph[v] == 1);
      if (vc_Val[v] && ph[v] != 1) nerr[v] = 1'b1;
    end
    if (write_i) begin
      w  = int'(input_Data.vc);
      ok = (is_head(input_Data.flit_label) ? (ph[w] == 0) : (ph[w] != 0)) && !endp[w]
           && (q[w].size() < BS || (pop && pv == w));
      if (!ok) nerr[w] = 1'b1;
    end
    if (pop) begin
      f = q[pv].pop_front();
      if (is_tail(f.flit_label)) begin ph[pv] = 0; endp[pv] = 0; nfree[pv] = 1'b1; end
    end
    for (int v = 0; v < NV; v++)
      if (valgo[v]) begin dvc[v] = vc_New[v*VC_Size +: VC_Size]; ph[v] = 2; end
    if (write_i && ok) begin
      q[w].push_back(input_Data);
      if (is_head(input_Data.flit_label)) begin ph[w] = 1; prt[w] = port_i; end
      if (is_tail(input_Data.flit_label)) endp[w] = 1;
    end
    for (int v = 0; v < NV; v++) if (nerr[v] && cnt[v] < 255) cnt[v]++;
    x_credit = pop; x_cvc = pop ? pv[VC_Size-1:0] : '0; x_free = nfree; x_err = nerr;
    @(posedge clk); #1;
    inputs_idle();
  endtask

  task automatic do_reset();
    inputs_idle();
    rst = 1'b1;
    #1;
    chk("rst_credit_o", credit_o, 0);
    chk("rst_credit_vc_o", credit_vc_o, 0);
    chk("rst_vc_Free", vc_Free, 0);
    chk("rst_err", err, 0);
    chk("rst_buf_empty", buf_empty, 4'b1111);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_vc_Req", vc_Req, 0);
    chk("rst_switch_Req", switch_Req, 0);
    chk("rst_output_Data", output_Data, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic rnd_step();
    int v, s, t;
    inputs_idle();
    if ($urandom_range(0, 9) < 6) begin
      v = $urandom_range(0, NV-1);
      if ($urandom_range(0, 9) == 0)  put(v, flit_label_t'($urandom_range(0, 3)), 16'($urandom), inout_Port'($urandom_range(0, 4)));
      else if (ph[v] == 0)            put(v, $urandom_range(0, 1) ? HEAD : HEADTAIL, 16'($urandom), inout_Port'($urandom_range(0, 4)));
      else                            put(v, ($urandom_range(0, 3) == 0) ? TAIL : BODY, 16'($urandom), inout_Port'($urandom_range(0, 4)));
    end
    for (int k = 0; k < NV; k++)
      if ((ph[k] == 1 && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0)
        grant(k, $urandom_range(0, NV-1));
    t = $urandom_range(0, 9);
    if (t < 5) begin
      s = $urandom_range(0, NV-1);
      for (int k = 0; k < NV; k++) begin
        v = (s + k) % NV;
        if (read_i == '0 && ph[v] == 2 && q[v].size() != 0) read_i[v] = 1'b1;
      end
    end else if (t == 9) read_i = NV'($urandom);
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    inputs_idle();
    do_reset();

    // Single HEADTAIL packet through VC1
    put(1, HEADTAIL, 16'h00A1, EAST); cycle();
    grant(1, 2); cycle();
    read_i = 4'b0010; #1;
    chk("t1_out_vc", output_Data.vc, 2);
    chk("t1_port_o", port_o, EAST);
    cycle();
    chk("t1_credit", credit_o, 1);
    chk("t1_credit_vc", credit_vc_o, 1);
    chk("t1_vc_free", vc_Free, 4'b0010);
    cycle();
    chk("t1_idle", vc_Req[1] | switch_Req[1], 0);

    // Fill VC0 with an 8-flit packet, overflow once, then drain
    put(0, HEAD, 16'h0100, NORTH); cycle();
    put(0, BODY, 16'h0101, LOCAL); grant(0, 3); cycle();
    for (int i = 2; i < 7; i++) begin put(0, BODY, 16'(16'h0100 + i), LOCAL); cycle(); end
    put(0, TAIL, 16'h0107, LOCAL); cycle();
    chk("t2_full", buf_full[0], 1);
    put(0, BODY, 16'h0108, LOCAL); cycle();
    chk("t2_overflow_err", err[0], 1);
    for (int i = 0; i < 8; i++) begin read_i = 4'b0001; cycle(); end
    cycle();
    chk("t2_empty", buf_empty[0], 1);

    // Interleaved packets on VC0 and VC3
    put(0, HEAD, 16'h0200, SOUTH); cycle();
    put(3, HEAD, 16'h0300, WEST); grant(0, 1); cycle();
    put(0, BODY, 16'h0201, LOCAL); grant(3, 2); cycle();
    for (int i = 0; i < 4; i++) begin
      put((i % 2) ? 3 : 0, (i >= 2) ? TAIL : BODY, 16'(16'h0400 + i), LOCAL);
      read_i = (i % 2) ? 4'b1000 : 4'b0001;
      cycle();
    end
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0 && q[0].size() != 0)    read_i = 4'b0001;
      else if (q[3].size() != 0)             read_i = 4'b1000;
      else if (q[0].size() != 0)             read_i = 4'b0001;
      cycle();
    end

    // Protocol errors on an idle VC2
    put(2, BODY, 16'h0500, LOCAL); cycle();
    chk("t4_body_idle_err", err, 4'b0100);
    vc_Val[2] = 1'b1; cycle();
    chk("t4_val_idle_err", err, 4'b0100);
    chk("t4_still_idle", vc_Req[2], 0);

    // Multi-hot grant, then reset mid-packet
    put(0, HEAD, 16'h0600, EAST); cycle();
    put(1, HEAD, 16'h0700, NORTH); grant(0, 3); cycle();
    grant(1, 0); cycle();
    read_i = 4'b0011; cycle();
    chk("t5_multi_err", err, 4'b0011);
    chk("t5_no_credit", credit_o, 0);
    put(1, BODY, 16'h0701, LOCAL); cycle();
    put(1, BODY, 16'h0702, LOCAL); cycle();
    chk("t6_vc1_not_empty", buf_empty[1], 0);
    do_reset();

    for (int i = 0; i < 2000; i++) rnd_step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
